// File: rtl/csr_file.sv
// Machine-mode CSR file at the write-back end of the CSR path.
// Optional 64-bit mcycle/minstret counters enabled by CSR_COUNTERS_EN.
module csr_file #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 12,
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              csr_we_in,
    input  logic [ADDR_W-1:0] csr_waddr_in,
    input  logic [DATA_W-1:0] csr_wdata_in,
    input  logic              instret_incr_in,
    input  logic              int_we_in,
    input  logic [ADDR_W-1:0] int_waddr_in,
    input  logic [DATA_W-1:0] int_wdata_in,
    input  logic              timer_irq_in,
    input  logic              ext_irq_in,
    input  logic [ADDR_W-1:0] csr_raddr_in,
    output logic [DATA_W-1:0] csr_rdata_out,
    output logic [DATA_W-1:0] mstatus_out,
    output logic [DATA_W-1:0] mie_out,
    output logic [DATA_W-1:0] mip_out,
    output logic [DATA_W-1:0] mtvec_out,
    output logic [DATA_W-1:0] mepc_out,
    output logic              global_int_en_out
);

    localparam logic [ADDR_W-1:0] A_MSTATUS  = ADDR_W'(12'h300);
    localparam logic [ADDR_W-1:0] A_MIE      = ADDR_W'(12'h304);
    localparam logic [ADDR_W-1:0] A_MTVEC    = ADDR_W'(12'h305);
    localparam logic [ADDR_W-1:0] A_MSCRATCH = ADDR_W'(12'h340);
    localparam logic [ADDR_W-1:0] A_MEPC     = ADDR_W'(12'h341);
    localparam logic [ADDR_W-1:0] A_MCAUSE   = ADDR_W'(12'h342);
    localparam logic [ADDR_W-1:0] A_MIP      = ADDR_W'(12'h344);

    localparam logic [DATA_W-1:0] MST_WMASK = DATA_W'(32'h0000_0088);
    localparam logic [DATA_W-1:0] MST_MPP   = DATA_W'(32'h0000_1800);
    localparam logic [DATA_W-1:0] MIE_WMASK = DATA_W'(32'h0000_0888);
    localparam logic [DATA_W-1:0] ALIGN4    = ~DATA_W'(3);

    localparam int I_MST = 0;
    localparam int I_MIE = 1;
    localparam int I_MTV = 2;
    localparam int I_MSC = 3;
    localparam int I_MEP = 4;
    localparam int I_MCA = 5;

`ifdef CSR_COUNTERS_EN
    localparam logic [ADDR_W-1:0] A_MCYCLE    = ADDR_W'(12'hB00);
    localparam logic [ADDR_W-1:0] A_MCYCLEH   = ADDR_W'(12'hB80);
    localparam logic [ADDR_W-1:0] A_MINSTRET  = ADDR_W'(12'hB02);
    localparam logic [ADDR_W-1:0] A_MINSTRETH = ADDR_W'(12'hB82);
    localparam logic [ADDR_W-1:0] A_CYCLE     = ADDR_W'(12'hC00);
    localparam logic [ADDR_W-1:0] A_CYCLEH    = ADDR_W'(12'hC80);
    localparam logic [ADDR_W-1:0] A_INSTRET   = ADDR_W'(12'hC02);
    localparam logic [ADDR_W-1:0] A_INSTRETH  = ADDR_W'(12'hC82);

    localparam int I_CYL = 6;
    localparam int I_CYH = 7;
    localparam int I_IRL = 8;
    localparam int I_IRH = 9;
    localparam int NW    = 10;

    localparam logic [ADDR_W-1:0] WA [NW] = '{
        A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
        A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH
    };
`else
    localparam int NW = 6;

    localparam logic [ADDR_W-1:0] WA [NW] = '{
        A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE
    };
`endif

    logic [NW-1:0]     wen;
    logic [DATA_W-1:0] wd [NW];

    logic [DATA_W-1:0] mstatus_q;
    logic [DATA_W-1:0] mie_q;
    logic [DATA_W-1:0] mtvec_q;
    logic [DATA_W-1:0] mscratch_q;
    logic [DATA_W-1:0] mepc_q;
    logic [DATA_W-1:0] mcause_q;
    logic              mtip_q;
    logic              meip_q;
    logic [DATA_W-1:0] mip_rd;
    logic [DATA_W-1:0] mstatus_rd;

    // Same-address collisions resolve to the interrupt port.
    always_comb begin
        for (int i = 0; i < NW; i++) begin
            wen[i] = (int_we_in && int_waddr_in == WA[i])
                  || (csr_we_in && csr_waddr_in == WA[i]);
            wd[i]  = (int_we_in && int_waddr_in == WA[i])
                   ? int_wdata_in : csr_wdata_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= DATA_W'(MTVEC_RESET) & ALIGN4;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtip_q     <= 1'b0;
            meip_q     <= 1'b0;
        end else begin
            if (wen[I_MST]) mstatus_q  <= wd[I_MST] & MST_WMASK;
            if (wen[I_MIE]) mie_q      <= wd[I_MIE] & MIE_WMASK;
            if (wen[I_MTV]) mtvec_q    <= wd[I_MTV] & ALIGN4;
            if (wen[I_MSC]) mscratch_q <= wd[I_MSC];
            if (wen[I_MEP]) mepc_q     <= wd[I_MEP] & ALIGN4;
            if (wen[I_MCA]) mcause_q   <= wd[I_MCA];
            mtip_q <= timer_irq_in;
            meip_q <= ext_irq_in;
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [2*DATA_W-1:0] mcycle_q;
    logic [2*DATA_W-1:0] minstret_q;

    // A written half blocks the increment for the whole counter.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (wen[I_CYL] || wen[I_CYH]) begin
                if (wen[I_CYL]) mcycle_q[DATA_W-1:0] <= wd[I_CYL];
                if (wen[I_CYH]) mcycle_q[2*DATA_W-1:DATA_W] <= wd[I_CYH];
            end else begin
                mcycle_q <= mcycle_q + 1'b1;
            end
            if (wen[I_IRL] || wen[I_IRH]) begin
                if (wen[I_IRL]) minstret_q[DATA_W-1:0] <= wd[I_IRL];
                if (wen[I_IRH]) minstret_q[2*DATA_W-1:DATA_W] <= wd[I_IRH];
            end else if (instret_incr_in) begin
                minstret_q <= minstret_q + 1'b1;
            end
        end
    end
`else
    logic unused_instret;
    assign unused_instret = instret_incr_in;
`endif

    always_comb begin
        mip_rd     = '0;
        mip_rd[7]  = mtip_q;
        mip_rd[11] = meip_q;
        mstatus_rd = mstatus_q | MST_MPP;
    end

    always_comb begin
        csr_rdata_out = '0;
        unique case (1'b1)
            csr_raddr_in == A_MSTATUS:  csr_rdata_out = mstatus_rd;
            csr_raddr_in == A_MIE:      csr_rdata_out = mie_q;
            csr_raddr_in == A_MTVEC:    csr_rdata_out = mtvec_q;
            csr_raddr_in == A_MSCRATCH: csr_rdata_out = mscratch_q;
            csr_raddr_in == A_MEPC:     csr_rdata_out = mepc_q;
            csr_raddr_in == A_MCAUSE:   csr_rdata_out = mcause_q;
            csr_raddr_in == A_MIP:      csr_rdata_out = mip_rd;
`ifdef CSR_COUNTERS_EN
            csr_raddr_in == A_MCYCLE || csr_raddr_in == A_CYCLE:
                csr_rdata_out = mcycle_q[DATA_W-1:0];
            csr_raddr_in == A_MCYCLEH || csr_raddr_in == A_CYCLEH:
                csr_rdata_out = mcycle_q[2*DATA_W-1:DATA_W];
            csr_raddr_in == A_MINSTRET || csr_raddr_in == A_INSTRET:
                csr_rdata_out = minstret_q[DATA_W-1:0];
            csr_raddr_in == A_MINSTRETH || csr_raddr_in == A_INSTRETH:
                csr_rdata_out = minstret_q[2*DATA_W-1:DATA_W];
`endif
            default: csr_rdata_out = '0;
        endcase
    end

    assign mstatus_out       = mstatus_rd;
    assign mie_out           = mie_q;
    assign mip_out           = mip_rd;
    assign mtvec_out         = mtvec_q;
    assign mepc_out          = mepc_q;
    assign global_int_en_out = mstatus_q[3];

endmodule

// File: tb/tb_csr_file.sv
// Randomized bench for csr_file against a register-map reference model.
// Counter checks follow CSR_COUNTERS_EN when it is defined for the bench too.
module tb_csr_file;

    localparam logic [31:0] MTV_RST = 32'h0000_1007;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        csr_we_in;
    logic [11:0] csr_waddr_in;
    logic [31:0] csr_wdata_in;
    logic        instret_incr_in;
    logic        int_we_in;
    logic [11:0] int_waddr_in;
    logic [31:0] int_wdata_in;
    logic        timer_irq_in;
    logic        ext_irq_in;
    logic [11:0] csr_raddr_in;
    logic [31:0] csr_rdata_out;
    logic [31:0] mstatus_out;
    logic [31:0] mie_out;
    logic [31:0] mip_out;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        global_int_en_out;

    csr_file #(
        .DATA_W(32), .ADDR_W(12), .MTVEC_RESET(MTV_RST)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .csr_we_in(csr_we_in), .csr_waddr_in(csr_waddr_in),
        .csr_wdata_in(csr_wdata_in), .instret_incr_in(instret_incr_in),
        .int_we_in(int_we_in), .int_waddr_in(int_waddr_in),
        .int_wdata_in(int_wdata_in), .timer_irq_in(timer_irq_in),
        .ext_irq_in(ext_irq_in), .csr_raddr_in(csr_raddr_in),
        .csr_rdata_out(csr_rdata_out), .mstatus_out(mstatus_out),
        .mie_out(mie_out), .mip_out(mip_out), .mtvec_out(mtvec_out),
        .mepc_out(mepc_out), .global_int_en_out(global_int_en_out)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Reference state: raw written words, masks applied when read.
    logic [31:0] m_mst, m_mie, m_mtv, m_msc, m_mepc, m_mca;
    logic        m_t, m_e;
    logic [63:0] m_cyc, m_ins;

    task automatic model_reset();
        m_mst = 0; m_mie = 0; m_mtv = MTV_RST; m_msc = 0;
        m_mepc = 0; m_mca = 0; m_t = 0; m_e = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    function automatic logic [31:0] model_rd(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (m_mst & 32'h88);
            12'h304: return m_mie & 32'h888;
            12'h305: return m_mtv & ~32'd3;
            12'h340: return m_msc;
            12'h341: return m_mepc & ~32'd3;
            12'h342: return m_mca;
            12'h344: return (32'(m_t) << 7) | (32'(m_e) << 11);
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: m_mst = d;
            12'h304: m_mie = d;
            12'h305: m_mtv = d;
            12'h340: m_msc = d;
            12'h341: m_mepc = d;
            12'h342: m_mca = d;
`ifdef CSR_COUNTERS_EN
            12'hB00: m_cyc[31:0] = d;
            12'hB80: m_cyc[63:32] = d;
            12'hB02: m_ins[31:0] = d;
            12'hB82: m_ins[63:32] = d;
`endif
            default: ;
        endcase
    endtask

    function automatic bit hits(input logic we, input logic [11:0] wa,
                                input logic [11:0] lo, input logic [11:0] hi);
        return we && (wa == lo || wa == hi);
    endfunction

    // One clock edge of the reference: increments, then WB write, then the
    // interrupt write so that it overrides WB on the same address.
    task automatic model_clock(input logic we, input logic [11:0] wa,
                               input logic [31:0] wd, input logic iw,
                               input logic [11:0] ia, input logic [31:0] id,
                               input logic inc, input logic t, input logic e,
                               input logic rst);
        bit cw, iwr;
        if (rst) begin
            model_reset();
            return;
        end
        cw  = hits(we, wa, 12'hB00, 12'hB80) || hits(iw, ia, 12'hB00, 12'hB80);
        iwr = hits(we, wa, 12'hB02, 12'hB82) || hits(iw, ia, 12'hB02, 12'hB82);
        if (!cw) m_cyc = m_cyc + 1;
        if (!iwr && inc) m_ins = m_ins + 1;
        if (we) model_write(wa, wd);
        if (iw) model_write(ia, id);
        m_t = t;
        m_e = e;
    endtask

    logic [31:0] rd_s, mip_s;
    logic        gie_s;
    logic        hold_t = 0, hold_e = 0;

    task automatic cyc(input logic we, input logic [11:0] wa,
                       input logic [31:0] wd, input logic iw,
                       input logic [11:0] ia, input logic [31:0] id,
                       input logic inc, input logic t, input logic e,
                       input logic [11:0] ra, input logic rst);
        csr_we_in = we; csr_waddr_in = wa; csr_wdata_in = wd;
        int_we_in = iw; int_waddr_in = ia; int_wdata_in = id;
        instret_incr_in = inc; timer_irq_in = t; ext_irq_in = e;
        csr_raddr_in = ra; reset_in = rst;
        @(negedge clk_in);
        rd_s = csr_rdata_out; mip_s = mip_out; gie_s = global_int_en_out;
        check($sformatf("rdata_%h", ra), csr_rdata_out, model_rd(ra));
        check("mstatus_out", mstatus_out, model_rd(12'h300));
        check("mie_out", mie_out, model_rd(12'h304));
        check("mip_out", mip_out, model_rd(12'h344));
        check("mtvec_out", mtvec_out, model_rd(12'h305));
        check("mepc_out", mepc_out, model_rd(12'h341));
        check("gie", {31'b0, global_int_en_out}, {31'b0, m_mst[3]});
        @(posedge clk_in);
        model_clock(we, wa, wd, iw, ia, id, inc, t, e, rst);
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        cyc(0, 0, 0, 0, 0, 0, 0, hold_t, hold_e, a, 0);
    endtask

    task automatic wb(input logic [11:0] a, input logic [31:0] d);
        cyc(1, a, d, 0, 0, 0, 0, hold_t, hold_e, a, 0);
    endtask

    localparam int NA = 18;
    localparam logic [11:0] ADDRS [NA] = '{
        12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
        12'h344, 12'hF14, 12'h301, 12'h7C0,
        12'hB00, 12'hB80, 12'hB02, 12'hB82,
        12'hC00, 12'hC80, 12'hC02, 12'hC82
    };

    task automatic check_reset_vals(input string pfx);
        logic [31:0] exp;
        for (int i = 0; i < 10; i++) begin
            rd(ADDRS[i]);
            exp = (ADDRS[i] == 12'h300) ? 32'h1800 :
                  (ADDRS[i] == 12'h305) ? 32'h1004 : 32'h0;
            check($sformatf("%s_%h", pfx, ADDRS[i]), rd_s, exp);
        end
        check({pfx, "_gie"}, {31'b0, gie_s}, 32'h0);
    endtask

    initial begin
        logic [11:0] wa, ia;
        logic        we, iw, rs;
        csr_we_in = 0; csr_waddr_in = 0; csr_wdata_in = 0;
        int_we_in = 0; int_waddr_in = 0; int_wdata_in = 0;
        instret_incr_in = 0; timer_irq_in = 0; ext_irq_in = 0;
        csr_raddr_in = 0; reset_in = 1;
        @(posedge clk_in);
        model_reset();
        #1;

        check_reset_vals("rst");
        for (int i = 10; i < NA; i++) rd(ADDRS[i]);

        wb(12'h300, 32'hFFFF_FFFF);
        rd(12'h300);
        check("mstatus_wr", rd_s, 32'h1888);
        check("gie_set", {31'b0, gie_s}, 32'h1);
        wb(12'h341, 32'h1003);
        rd(12'h341);
        check("mepc_align", rd_s, 32'h1000);

        cyc(1, 12'h342, 32'h5, 1, 12'h342, 32'h8000_000B, 0, 0, 0, 12'h342, 0);
        rd(12'h342);
        check("same_addr_int_wins", rd_s, 32'h8000_000B);
        cyc(1, 12'h342, 32'h11, 1, 12'h341, 32'h2000, 0, 0, 0, 12'h342, 0);
        rd(12'h342);
        check("diff_addr_wb", rd_s, 32'h11);
        rd(12'h341);
        check("diff_addr_int", rd_s, 32'h2000);

        hold_t = 1;
        rd(12'h344);
        check("mip_lag", mip_s & 32'h80, 32'h0);
        rd(12'h344);
        check("mip_set", rd_s, 32'h80);
        wb(12'h344, 32'h0);
        rd(12'h344);
        check("mip_ro", rd_s, 32'h80);
        hold_t = 0;

`ifdef CSR_COUNTERS_EN
        wb(12'hB00, 32'hFFFF_FFFF);
        wb(12'hB80, 32'hFFFF_FFFF);
        rd(12'hB80);
        check("mcycleh_full", rd_s, 32'hFFFF_FFFF);
        rd(12'hB00);
        check("mcycle_wrap", rd_s, 32'h0);
        rd(12'hB80);
        check("mcycleh_wrap", rd_s, 32'h0);
        wb(12'hB02, 32'h0);
        wb(12'hB82, 32'h0);
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 12'hB02, 0);
        rd(12'hB02);
        check("minstret_3", rd_s, 32'h3);
        cyc(1, 12'hB02, 32'h10, 0, 0, 0, 1, 0, 0, 12'hB02, 0);
        rd(12'hB02);
        check("minstret_wr_wins", rd_s, 32'h10);
`else
        for (int i = 0; i < 100; i++)
            cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 12'hB00, 0);
        check("nocnt_read", rd_s, 32'h0);
        wb(12'hB00, 32'h1234);
        rd(12'hB00);
        check("nocnt_write", rd_s, 32'h0);
`endif

        for (int n = 0; n < 400; n++) begin
            wa = ADDRS[$urandom_range(0, NA - 1)];
            ia = ($urandom_range(0, 2) == 0) ? wa
                 : ADDRS[$urandom_range(0, NA - 1)];
            we = ($urandom_range(0, 1) == 1);
            iw = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 63) == 0);
            cyc(we, wa, $urandom(), iw, ia, $urandom(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ADDRS[$urandom_range(0, NA - 1)],
                rs);
        end

        cyc(1, 12'h340, 32'hDEAD_BEEF, 1, 12'h300, 32'h8, 1, 1, 1, 12'h300, 1);
        check_reset_vals("midrst");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
